sync_debounce: RTL and testbench



---
 rtl/sync_debounce.sv | 158 +++++++++++++++
 tb/tb_sync_debounce.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// sync_debounce: multi-stage synchronizer followed by a counter-based debounce FSM.
// Turns an asynchronous, bouncy level on d into a clean synchronous level on q.
// The optional rise/fall edge-pulse outputs are compiled in only when the
// macro SYNC_DEBOUNCE_EDGE_PULSE_EN is defined.
module sync_debounce #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 50000,
    parameter int   CNT_W         = 16,
    parameter logic INIT          = 1'b0
) (
    input  logic c,
    input  logic r_n,
    input  logic d,
    output logic q,
    output logic busy
`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    // State encoding: bit 1 is the level on q, bit 0 is busy.
    localparam logic [1:0] ST_STABLE_LO = 2'b00;
    localparam logic [1:0] ST_WAIT_HI   = 2'b01;
    localparam logic [1:0] ST_STABLE_HI = 2'b10;
    localparam logic [1:0] ST_WAIT_LO   = 2'b11;
    localparam logic [1:0] ST_RESET     = {INIT, 1'b0};

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    // With a one-cycle requirement the first differing sample commits directly.
    localparam logic             SINGLE   = (STABLE_CYCLES == 1) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   q_r;
    logic                   busy_r;
    logic                   q_nxt_s;
    logic                   busy_nxt_s;

    // Synchronizer chain: plain shift of d through SYNC_STAGES flops, no logic between stages.
    always_ff @(posedge c or negedge r_n) begin
        if (!r_n) begin
            sync_r <= {SYNC_STAGES{INIT}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
        end
    end

    assign s_s = sync_r[SYNC_STAGES-1];

    // Debounce FSM next-state and counter logic; the counter is cleared on every WAIT exit.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_STABLE_LO: begin
                if (s_s) begin
                    if (SINGLE) begin
                        state_nxt_s = ST_STABLE_HI;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_WAIT_HI;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            ST_WAIT_HI: begin
                if (!s_s) begin
                    state_nxt_s = ST_STABLE_LO;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_STABLE_HI;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STABLE_HI: begin
                if (!s_s) begin
                    if (SINGLE) begin
                        state_nxt_s = ST_STABLE_LO;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_WAIT_LO;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            ST_WAIT_LO: begin
                if (s_s) begin
                    state_nxt_s = ST_STABLE_HI;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_STABLE_LO;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_RESET;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    assign q_nxt_s    = state_nxt_s[1];
    assign busy_nxt_s = state_nxt_s[0];

    // FSM state, stability counter and registered q/busy outputs.
    always_ff @(posedge c or negedge r_n) begin
        if (!r_n) begin
            state_r <= ST_RESET;
            cnt_r   <= CNT_ZERO;
            q_r     <= INIT;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            q_r     <= q_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign q    = q_r;
    assign busy = busy_r;

`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
    logic rise_r;
    logic fall_r;

    // One-cycle pulses coincident with the new q value; reset itself never pulses.
    always_ff @(posedge c or negedge r_n) begin
        if (!r_n) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= ~q_r & q_nxt_s;
            fall_r <= q_r & ~q_nxt_s;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Directed self-checking bench for sync_debounce.
// dut1: SYNC_STAGES=2, STABLE_CYCLES=4, CNT_W=4, INIT=0.
// dut2: SYNC_STAGES=2, STABLE_CYCLES=1, CNT_W=4, INIT=1.
module tb_sync_debounce;

    logic c;
    logic r_n;
    logic d;
    logic q;
    logic busy;
    logic d2;
    logic q2;
    logic busy2;
`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
    logic rise;
    logic fall;
    logic rise2;
    logic fall2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sync_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(4), .INIT(1'b0)) dut1 (
        .c(c), .r_n(r_n), .d(d), .q(q), .busy(busy)
`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
        , .rise(rise), .fall(fall)
`endif
    );

    sync_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_W(4), .INIT(1'b1)) dut2 (
        .c(c), .r_n(r_n), .d(d2), .q(q2), .busy(busy2)
`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
        , .rise(rise2), .fall(fall2)
`endif
    );

    initial c = 1'b0;
    always #5 c = ~c;

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge c);
            #1;
        end
    endtask

    // Drive d to lvl and wait until q has followed (6 edges for dut1).
    task automatic settle_dut1(input logic lvl);
        d = lvl;
        step(6);
        n_tests++;
        if (q !== lvl) begin n_fail++; $display("FAIL settle_q got %b exp %b", q, lvl); end
    endtask

    task automatic test_reset();
        r_n = 1'b1; d = 1'b0; d2 = 1'b1;
        #1;
        r_n = 1'b0;
        d = 1'b1;
        step(5);
        n_tests++;
        if (q !== 1'b0) begin n_fail++; $display("FAIL reset_q got %b exp 0", q); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++;
        if (q2 !== 1'b1) begin n_fail++; $display("FAIL reset_q2 got %b exp 1", q2); end
        n_tests++;
        if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy2 got %b exp 0", busy2); end
`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
        n_tests++;
        if ({rise, fall, rise2, fall2} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses got %b exp 0000", {rise, fall, rise2, fall2});
        end
`endif
        r_n = 1'b1;
        step(1);
`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
        n_tests++;
        if ({rise2, fall2} !== 2'b00) begin
            n_fail++; $display("FAIL release_pulses2 got %b exp 00", {rise2, fall2});
        end
`endif
        step(4);
        n_tests++;
        if (q !== 1'b0) begin n_fail++; $display("FAIL release_q5 got %b exp 0", q); end
        step(1);
        n_tests++;
        if (q !== 1'b1) begin n_fail++; $display("FAIL release_q6 got %b exp 1", q); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL release_busy6 got %b exp 0", busy); end
    endtask

    task automatic test_clean_fall();
        d = 1'b0;
        step(5);
        n_tests++;
        if ({q, busy} !== 2'b11) begin n_fail++; $display("FAIL fall_wait got %b exp 11", {q, busy}); end
        step(1);
        n_tests++;
        if ({q, busy} !== 2'b00) begin n_fail++; $display("FAIL fall_done got %b exp 00", {q, busy}); end
    endtask

    task automatic test_clean_rise();
        d = 1'b1;
        step(2);
        n_tests++;
        if ({q, busy} !== 2'b00) begin n_fail++; $display("FAIL rise_e2 got %b exp 00", {q, busy}); end
        step(1);
        n_tests++;
        if ({q, busy} !== 2'b01) begin n_fail++; $display("FAIL rise_e3 got %b exp 01", {q, busy}); end
        step(2);
        n_tests++;
        if ({q, busy} !== 2'b01) begin n_fail++; $display("FAIL rise_e5 got %b exp 01", {q, busy}); end
`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
        n_tests++;
        if (rise !== 1'b0) begin n_fail++; $display("FAIL rise_pulse_e5 got %b exp 0", rise); end
`endif
        step(1);
        n_tests++;
        if ({q, busy} !== 2'b10) begin n_fail++; $display("FAIL rise_e6 got %b exp 10", {q, busy}); end
`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
        n_tests++;
        if ({rise, fall} !== 2'b10) begin n_fail++; $display("FAIL rise_pulse_e6 got %b exp 10", {rise, fall}); end
        step(1);
        n_tests++;
        if ({rise, fall} !== 2'b00) begin n_fail++; $display("FAIL rise_pulse_e7 got %b exp 00", {rise, fall}); end
`endif
    endtask

    task automatic test_glitch();
        logic saw_busy;
        logic q_moved;
        settle_dut1(1'b0);
        saw_busy = 1'b0;
        q_moved  = 1'b0;
        d = 1'b1;
        step(2);
        d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (busy === 1'b1) saw_busy = 1'b1;
            if (q !== 1'b0) q_moved = 1'b1;
        end
        n_tests++;
        if (q_moved !== 1'b0) begin n_fail++; $display("FAIL glitch_q_moved got %b exp 0", q_moved); end
        n_tests++;
        if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_saw_busy got %b exp 1", saw_busy); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end got %b exp 0", busy); end
        d = 1'b1;
        step(5);
        n_tests++;
        if (q !== 1'b0) begin n_fail++; $display("FAIL glitch_retime_e5 got %b exp 0", q); end
        step(1);
        n_tests++;
        if (q !== 1'b1) begin n_fail++; $display("FAIL glitch_retime_e6 got %b exp 1", q); end
    endtask

    task automatic test_bounce();
        logic q_moved;
        settle_dut1(1'b0);
        q_moved = 1'b0;
        d = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d = ~d;
            step(1);
            if (q !== 1'b0) q_moved = 1'b1;
        end
        n_tests++;
        if (q_moved !== 1'b0) begin n_fail++; $display("FAIL bounce_q_moved got %b exp 0", q_moved); end
        d = 1'b1;
        step(5);
        n_tests++;
        if (q !== 1'b0) begin n_fail++; $display("FAIL bounce_settle_e5 got %b exp 0", q); end
        step(1);
        n_tests++;
        if (q !== 1'b1) begin n_fail++; $display("FAIL bounce_settle_e6 got %b exp 1", q); end
    endtask

    task automatic test_reset_mid_wait();
        settle_dut1(1'b0);
        d = 1'b1;
        step(4);
        n_tests++;
        if ({q, busy} !== 2'b01) begin n_fail++; $display("FAIL midwait_pre got %b exp 01", {q, busy}); end
        #2;
        r_n = 1'b0;
        #1;
        n_tests++;
        if ({q, busy} !== 2'b00) begin n_fail++; $display("FAIL midwait_async got %b exp 00", {q, busy}); end
        step(1);
        n_tests++;
        if ({q, busy} !== 2'b00) begin n_fail++; $display("FAIL midwait_held got %b exp 00", {q, busy}); end
        r_n = 1'b1;
        step(5);
        n_tests++;
        if (q !== 1'b0) begin n_fail++; $display("FAIL midwait_retime_e5 got %b exp 0", q); end
        step(1);
        n_tests++;
        if (q !== 1'b1) begin n_fail++; $display("FAIL midwait_retime_e6 got %b exp 1", q); end
    endtask

    task automatic test_single_cycle();
        logic saw_busy2;
        saw_busy2 = 1'b0;
        n_tests++;
        if (q2 !== 1'b1) begin n_fail++; $display("FAIL single_start got %b exp 1", q2); end
        d2 = 1'b0;
        step(2);
        if (busy2 !== 1'b0) saw_busy2 = 1'b1;
        n_tests++;
        if (q2 !== 1'b1) begin n_fail++; $display("FAIL single_e2 got %b exp 1", q2); end
`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
        n_tests++;
        if (fall2 !== 1'b0) begin n_fail++; $display("FAIL single_fall_e2 got %b exp 0", fall2); end
`endif
        step(1);
        if (busy2 !== 1'b0) saw_busy2 = 1'b1;
        n_tests++;
        if (q2 !== 1'b0) begin n_fail++; $display("FAIL single_e3 got %b exp 0", q2); end
`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
        n_tests++;
        if ({rise2, fall2} !== 2'b01) begin n_fail++; $display("FAIL single_pulse_e3 got %b exp 01", {rise2, fall2}); end
`endif
        step(1);
        if (busy2 !== 1'b0) saw_busy2 = 1'b1;
`ifdef SYNC_DEBOUNCE_EDGE_PULSE_EN
        n_tests++;
        if ({rise2, fall2} !== 2'b00) begin n_fail++; $display("FAIL single_pulse_e4 got %b exp 00", {rise2, fall2}); end
`endif
        step(3);
        if (busy2 !== 1'b0) saw_busy2 = 1'b1;
        n_tests++;
        if (saw_busy2 !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b exp 0", saw_busy2); end
        n_tests++;
        if (q2 !== 1'b0) begin n_fail++; $display("FAIL single_hold got %b exp 0", q2); end
    endtask

    initial begin
        test_reset();
        test_clean_fall();
        test_clean_rise();
        test_glitch();
        test_bounce();
        test_reset_mid_wait();
        test_single_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
